// File: rtl/timepulse_gen_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : timepulse_gen_if
//  Description : Control and strobe bundle between the timepulse generator
//                and its surroundings (run/step/restart control in, the
//                T01..T12 timepulses, phase strobes and MCT status out).
//                master = controller/harness side, slave = timepulse_gen.
//  Signals     : RUN, STOP_REQ, STEP, GOJAM       control (master -> slave)
//                T_n[11:0], T10_n                 active-low timepulses
//                RT_n, WT_n, TT_n, CT_n           active-low phase strobes
//                MCT_END, HALTED, MCT_COUNT       MCT status
//  Revision    : 1.0  initial release
// ============================================================================
interface timepulse_gen_if #(
    parameter int CNT_W = 16
);
    logic             RUN;
    logic             STOP_REQ;
    logic             STEP;
    logic             GOJAM;
    logic [11:0]      T_n;
    logic             T10_n;
    logic             RT_n;
    logic             WT_n;
    logic             TT_n;
    logic             CT_n;
    logic             MCT_END;
    logic             HALTED;
    logic [CNT_W-1:0] MCT_COUNT;

    modport master (
        output RUN, STOP_REQ, STEP, GOJAM,
        input  T_n, T10_n, RT_n, WT_n, TT_n, CT_n, MCT_END, HALTED, MCT_COUNT
    );

    modport slave (
        input  RUN, STOP_REQ, STEP, GOJAM,
        output T_n, T10_n, RT_n, WT_n, TT_n, CT_n, MCT_END, HALTED, MCT_COUNT
    );
endinterface
`default_nettype wire

// File: rtl/timepulse_gen.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : timepulse_gen
//  Description : Memory-cycle-time sequencer. One MCT is twelve timepulses
//                (T01..T12) of PHASES clocks each; within a timepulse the
//                phases carry the read (ph0), write (ph1), transfer (ph2) and
//                clear (last phase) strobes. Supports continuous run, halt at
//                end of MCT, single-MCT step and GOJAM restart, and counts
//                completed MCTs.
//  Ports       : SIM_CLK  system clock (rising edge)
//                SIM_RST  synchronous active-high reset
//                bus      timepulse_gen_if.slave (control in, strobes/status out)
//  Parameters  : PHASES   clocks per timepulse (>= 4)
//                CNT_W    width of MCT_COUNT (must match the interface)
//  Revision    : 1.0  initial release
// ============================================================================
module timepulse_gen #(
    parameter int PHASES = 4,
    parameter int CNT_W  = 16
) (
    input  wire logic          SIM_CLK,
    input  wire logic          SIM_RST,
    timepulse_gen_if.slave     bus
);

    localparam int              PH_W    = $clog2(PHASES);
    localparam logic [PH_W-1:0] PH_RD   = PH_W'(0);
    localparam logic [PH_W-1:0] PH_WR   = PH_W'(1);
    localparam logic [PH_W-1:0] PH_TR   = PH_W'(2);
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(PHASES - 1);
    localparam logic [3:0]      TP_LAST = 4'd11;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } mode_t;

    // sequencing state
    mode_t              mode_q, mode_d;
    logic [3:0]         tp_q, tp_d;
    logic [PH_W-1:0]    ph_q, ph_d;
    logic               step_q, step_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    // registered outputs
    logic [11:0]        t_n_q;
    logic               t10_n_q, rt_n_q, wt_n_q, tt_n_q, ct_n_q;
    logic               mct_end_q, halted_q;

    // outputs decoded from the next state, so the registered copies always
    // describe the state they are registered alongside
    logic [11:0]        t_n_d;
    logic               t10_n_d, rt_n_d, wt_n_d, tt_n_d, ct_n_d;
    logic               mct_end_d, halted_d;

    logic               mct_end_now;
    logic               run_d;

    assign mct_end_now = (mode_q == S_RUN) && (tp_q == TP_LAST) && (ph_q == PH_LAST);

    always_comb begin
        mode_d = mode_q;
        tp_d   = tp_q;
        ph_d   = ph_q;
        step_d = step_q;
        cnt_d  = cnt_q;

        case (mode_q)
            S_IDLE: begin
                // GOJAM has no effect while halted; RUN wins over STEP
                if (bus.RUN) begin
                    mode_d = S_RUN;
                    tp_d   = 4'd0;
                    ph_d   = PH_RD;
                    step_d = 1'b0;
                end else if (bus.STEP) begin
                    mode_d = S_RUN;
                    tp_d   = 4'd0;
                    ph_d   = PH_RD;
                    step_d = 1'b1;
                end
            end
            S_RUN: begin
                if (bus.GOJAM) begin
                    // abort: restart at T01 ph0, the aborted MCT is not counted
                    tp_d   = 4'd0;
                    ph_d   = PH_RD;
                    step_d = 1'b0;
                end else if (mct_end_now) begin
                    // RUN/STOP_REQ are only looked at here; a single step
                    // always halts after its one MCT
                    cnt_d = cnt_q + CNT_W'(1);
                    tp_d  = 4'd0;
                    ph_d  = PH_RD;
                    if (bus.STOP_REQ || !bus.RUN || step_q) begin
                        mode_d = S_IDLE;
                        step_d = 1'b0;
                    end
                end else if (ph_q == PH_LAST) begin
                    ph_d = PH_RD;
                    tp_d = tp_q + 4'd1;
                end else begin
                    ph_d = ph_q + PH_W'(1);
                end
            end
            default: begin
                mode_d = S_IDLE;
            end
        endcase

        run_d     = (mode_d == S_RUN);
        t_n_d     = run_d ? ~(12'd1 << tp_d) : 12'hFFF;
        t10_n_d   = !(run_d && (tp_d == 4'd9));
        rt_n_d    = !(run_d && (ph_d == PH_RD));
        wt_n_d    = !(run_d && (ph_d == PH_WR));
        tt_n_d    = !(run_d && (ph_d == PH_TR));
        ct_n_d    = !(run_d && (ph_d == PH_LAST));
        mct_end_d = run_d && (tp_d == TP_LAST) && (ph_d == PH_LAST);
        halted_d  = !run_d;
    end

    always_ff @(posedge SIM_CLK) begin
        if (SIM_RST) begin
            mode_q    <= S_IDLE;
            tp_q      <= 4'd0;
            ph_q      <= PH_RD;
            step_q    <= 1'b0;
            cnt_q     <= '0;
            t_n_q     <= 12'hFFF;
            t10_n_q   <= 1'b1;
            rt_n_q    <= 1'b1;
            wt_n_q    <= 1'b1;
            tt_n_q    <= 1'b1;
            ct_n_q    <= 1'b1;
            mct_end_q <= 1'b0;
            halted_q  <= 1'b1;
        end else begin
            mode_q    <= mode_d;
            tp_q      <= tp_d;
            ph_q      <= ph_d;
            step_q    <= step_d;
            cnt_q     <= cnt_d;
            t_n_q     <= t_n_d;
            t10_n_q   <= t10_n_d;
            rt_n_q    <= rt_n_d;
            wt_n_q    <= wt_n_d;
            tt_n_q    <= tt_n_d;
            ct_n_q    <= ct_n_d;
            mct_end_q <= mct_end_d;
            halted_q  <= halted_d;
        end
    end

    assign bus.T_n       = t_n_q;
    assign bus.T10_n     = t10_n_q;
    assign bus.RT_n      = rt_n_q;
    assign bus.WT_n      = wt_n_q;
    assign bus.TT_n      = tt_n_q;
    assign bus.CT_n      = ct_n_q;
    assign bus.MCT_END   = mct_end_q;
    assign bus.HALTED    = halted_q;
    assign bus.MCT_COUNT = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_timepulse_gen.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_timepulse_gen
//  Description : Self-checking bench for timepulse_gen. A flat model tracks
//                mode, the cycle index within the MCT (0..12*PHASES-1), the
//                step flag and the completed-MCT count; expected pins are
//                decoded from that index. A second instance with a 2-bit
//                counter shares all inputs to exercise counter wrap.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_timepulse_gen;

    localparam int P   = 4;
    localparam int MCT = 12 * P;
    localparam logic [34:0] RESET_VEC = {12'hFFF, 7'b1111101, 16'h0000};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst  = 1'b1;
    logic run  = 1'b0;
    logic stop = 1'b0;
    logic step = 1'b0;
    logic goj  = 1'b0;

    timepulse_gen_if #(.CNT_W(16)) ifm ();
    timepulse_gen_if #(.CNT_W(2))  ifw ();

    assign ifm.RUN = run;  assign ifm.STOP_REQ = stop;  assign ifm.STEP = step;  assign ifm.GOJAM = goj;
    assign ifw.RUN = run;  assign ifw.STOP_REQ = stop;  assign ifw.STEP = step;  assign ifw.GOJAM = goj;

    timepulse_gen #(.PHASES(P), .CNT_W(16)) u_dut (
        .SIM_CLK (clk),
        .SIM_RST (rst),
        .bus     (ifm)
    );

    timepulse_gen #(.PHASES(P), .CNT_W(2)) u_dut_w (
        .SIM_CLK (clk),
        .SIM_RST (rst),
        .bus     (ifw)
    );

    logic [34:0] dut_vec;
    assign dut_vec = {ifm.T_n, ifm.T10_n, ifm.RT_n, ifm.WT_n, ifm.TT_n, ifm.CT_n,
                      ifm.MCT_END, ifm.HALTED, ifm.MCT_COUNT};

    int total = 0;
    int bad   = 0;

    // reference model
    bit m_run  = 1'b0;
    bit m_step = 1'b0;
    int m_idx  = 0;
    int m_cnt  = 0;

    task automatic model_step();
        if (rst) begin
            m_run = 0; m_step = 0; m_idx = 0; m_cnt = 0;
        end else if (!m_run) begin
            if (run)       begin m_run = 1; m_idx = 0; m_step = 0; end
            else if (step) begin m_run = 1; m_idx = 0; m_step = 1; end
        end else if (goj) begin
            m_idx = 0; m_step = 0;
        end else if (m_idx == MCT - 1) begin
            m_cnt = m_cnt + 1;
            m_idx = 0;
            if (stop || !run || m_step) begin m_run = 0; m_step = 0; end
        end else begin
            m_idx = m_idx + 1;
        end
    endtask

    function automatic logic [34:0] exp_vec();
        int tp = m_idx / P;
        int ph = m_idx % P;
        logic [11:0] t = 12'hFFF;
        logic [15:0] c = 16'(m_cnt);
        if (m_run) t[tp] = 1'b0;
        return {t, !(m_run && tp == 9), !(m_run && ph == 0), !(m_run && ph == 1),
                !(m_run && ph == 2), !(m_run && ph == P - 1),
                (m_run && m_idx == MCT - 1), !m_run, c};
    endfunction

    // advance one clock: model consumes the same inputs the DUT samples
    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1; run = 0; stop = 0; step = 0; goj = 0;
        tick(); tick();
        total++;
        if (dut_vec !== RESET_VEC) begin
            bad++; $display("FAIL reset_vals got=%h exp=%h", dut_vec, RESET_VEC);
        end
        rst = 0; goj = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if (dut_vec !== exp_vec()) begin
                bad++; $display("FAIL idle_gojam cyc=%0d got=%h exp=%h", i, dut_vec, exp_vec());
            end
        end
        goj = 0;
    endtask

    task automatic test_start();
        run = 1;
        tick();
        total++;
        if ({ifm.HALTED, ifm.T_n, ifm.RT_n} !== {1'b0, 12'hFFE, 1'b0}) begin
            bad++; $display("FAIL start_k1 got=%b_%h_%b exp=0_ffe_0", ifm.HALTED, ifm.T_n, ifm.RT_n);
        end
        for (int i = 2; i <= 5; i++) begin
            tick();
            total++;
            if (dut_vec !== exp_vec()) begin
                bad++; $display("FAIL start_k%0d got=%h exp=%h", i, dut_vec, exp_vec());
            end
        end
        total++;
        if ({ifm.T_n, ifm.RT_n} !== {12'hFFD, 1'b0}) begin
            bad++; $display("FAIL start_k5 got=%h_%b exp=ffd_0", ifm.T_n, ifm.RT_n);
        end
    endtask

    task automatic test_continuous();
        int ends = 0;
        int multi = 0;
        rst = 1; tick(); rst = 0; run = 1;
        for (int i = 1; i <= 3 * MCT + 1; i++) begin
            tick();
            if (ifm.MCT_END) ends++;
            if ($countones({ifm.RT_n, ifm.WT_n, ifm.TT_n, ifm.CT_n}) != 3) multi++;
            total++;
            if (dut_vec !== exp_vec()) begin
                bad++; $display("FAIL cont cyc=%0d got=%h exp=%h", i, dut_vec, exp_vec());
            end
        end
        total++;
        if (ends != 3 || multi != 0 || ifm.MCT_COUNT !== 16'd3) begin
            bad++; $display("FAIL cont_summary ends=%0d multi=%0d cnt=%0d exp 3/0/3", ends, multi, ifm.MCT_COUNT);
        end
    endtask

    task automatic test_stop();
        int n = 0;
        bit saw_end = 0;
        while (m_idx != 4 * P && n < 200) begin tick(); n++; end
        stop = 1;
        n = 0;
        while (!ifm.HALTED && n < 100) begin
            saw_end = ifm.MCT_END;
            tick(); n++;
            total++;
            if (dut_vec !== exp_vec()) begin
                bad++; $display("FAIL stop cyc=%0d got=%h exp=%h", n, dut_vec, exp_vec());
            end
        end
        total++;
        if (!ifm.HALTED || !saw_end || ifm.T_n !== 12'hFFF || ifm.MCT_COUNT !== 16'd4) begin
            bad++; $display("FAIL stop_halt halted=%b end_before=%b T_n=%h cnt=%0d exp 1/1/fff/4",
                            ifm.HALTED, saw_end, ifm.T_n, ifm.MCT_COUNT);
        end
        stop = 0; run = 0;
    endtask

    task automatic test_step();
        int running = 0;
        int n = 0;
        tick();
        step = 1; tick(); step = 0;
        if (!ifm.HALTED) running++;
        while (!ifm.HALTED && n < 100) begin
            step = (n == 10);
            tick(); n++;
            if (!ifm.HALTED) running++;
            total++;
            if (dut_vec !== exp_vec()) begin
                bad++; $display("FAIL step cyc=%0d got=%h exp=%h", n, dut_vec, exp_vec());
            end
        end
        step = 0;
        total++;
        if (running != MCT || ifm.MCT_COUNT !== 16'd5 || !ifm.HALTED) begin
            bad++; $display("FAIL step_len running=%0d cnt=%0d halted=%b exp 48/5/1", running, ifm.MCT_COUNT, ifm.HALTED);
        end
    endtask

    task automatic test_gojam();
        int n = 0;
        int ends = 0;
        run = 1; tick();
        while (m_idx != 4 * P + 2 && n < 200) begin tick(); n++; end
        goj = 1; tick(); goj = 0;
        total++;
        if ({ifm.T_n, ifm.RT_n, ifm.MCT_COUNT} !== {12'hFFE, 1'b0, 16'd5}) begin
            bad++; $display("FAIL gojam_mid got=%h_%b_%0d exp=ffe_0_5", ifm.T_n, ifm.RT_n, ifm.MCT_COUNT);
        end
        n = 0;
        while (m_idx != MCT - 1 && n < 200) begin
            tick(); n++;
            if (m_idx != MCT - 1 && ifm.MCT_END) ends++;
            total++;
            if (dut_vec !== exp_vec()) begin
                bad++; $display("FAIL gojam_run cyc=%0d got=%h exp=%h", n, dut_vec, exp_vec());
            end
        end
        total++;
        if (ends != 0 || ifm.MCT_END !== 1'b1 || n != MCT - 1) begin
            bad++; $display("FAIL gojam_restart ends=%0d end=%b cyc=%0d exp 0/1/47", ends, ifm.MCT_END, n);
        end
        goj = 1;
        for (int i = 0; i < 4; i++) begin
            tick();
            total++;
            if ({ifm.T_n, ifm.RT_n, ifm.MCT_END, ifm.MCT_COUNT} !== {12'hFFE, 1'b0, 1'b0, 16'd5}) begin
                bad++; $display("FAIL gojam_end i=%0d got=%h_%b_%b_%0d exp=ffe_0_0_5",
                                i, ifm.T_n, ifm.RT_n, ifm.MCT_END, ifm.MCT_COUNT);
            end
        end
        goj = 0;
    endtask

    task automatic test_reset_mid();
        int n = 0;
        rst = 1; tick(); rst = 0; run = 1;
        for (int i = 0; i < 2 * MCT + 1; i++) tick();
        while (m_idx != 7 * P + 1 && n < 200) begin tick(); n++; end
        total++;
        if (ifm.MCT_COUNT !== 16'd2 || ifm.T_n !== 12'hF7F || ifm.WT_n !== 1'b0) begin
            bad++; $display("FAIL rstmid_pre cnt=%0d T_n=%h WT_n=%b exp 2/f7f/0", ifm.MCT_COUNT, ifm.T_n, ifm.WT_n);
        end
        rst = 1; tick();
        total++;
        if (dut_vec !== RESET_VEC) begin
            bad++; $display("FAIL rstmid got=%h exp=%h", dut_vec, RESET_VEC);
        end
        rst = 0;
    endtask

    task automatic test_wrap();
        run = 1;
        for (int i = 0; i < 4 * MCT + 1; i++) begin
            tick();
            total++;
            if (ifw.MCT_COUNT !== 2'(m_cnt % 4)) begin
                bad++; $display("FAIL wrap_track cyc=%0d got=%0d exp=%0d", i, ifw.MCT_COUNT, m_cnt % 4);
            end
        end
        total++;
        if (ifw.MCT_COUNT !== 2'd0 || ifm.MCT_COUNT !== 16'd4) begin
            bad++; $display("FAIL wrap got=%0d/%0d exp=0/4", ifw.MCT_COUNT, ifm.MCT_COUNT);
        end
        run = 0;
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            run  = ($urandom_range(0, 3) != 0);
            stop = ($urandom_range(0, 7) == 0);
            step = ($urandom_range(0, 15) == 0);
            goj  = ($urandom_range(0, 63) == 0);
            rst  = ($urandom_range(0, 511) == 0);
            tick();
            total++;
            if (dut_vec !== exp_vec() || ifw.MCT_COUNT !== 2'(m_cnt % 4)) begin
                bad++; $display("FAIL random cyc=%0d got=%h/%0d exp=%h/%0d", i, dut_vec, ifw.MCT_COUNT,
                                exp_vec(), m_cnt % 4);
            end
        end
        rst = 0; run = 0; stop = 0; step = 0; goj = 0;
    endtask

    initial begin
        test_reset();
        test_start();
        test_continuous();
        test_stop();
        test_step();
        test_gojam();
        test_reset_mid();
        test_wrap();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
